i2s_frame_receiver: RTL and testbench

- Receive-side I2S deserializer. Consumes the serial stream from the I2S sound transmitter (word_select, serial data bit) and recovers parallel left/right PCM samples.
- Checks every channel slot for correct length and flags framing errors.
- Sits directly downstream of the transmitter; drives the parallel sample path into the audio processing chain. Also used as the loopback checker for transmitter test builds.

---
 rtl/i2s_frame_receiver.sv | 169 ++++++++++++++++
 tb/tb_i2s_frame_receiver.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_frame_receiver.sv
// I2S receive deserializer: recovers left/right PCM samples and flags slots of the wrong length.
// Define I2S_RX_ERR_CNT_EN to add a saturating frame-error counter (err_count) with synchronous clear (err_clear).
module i2s_frame_receiver #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SLOT_BITS  = 17
) (
    input  logic                  serial_clk,
    input  logic                  reset,
    input  logic                  ws_in,
    input  logic                  sd_in,
`ifdef I2S_RX_ERR_CNT_EN
    input  logic                  err_clear,
    output logic [7:0]            err_count,
`endif
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  left_valid,
    output logic                  right_valid,
    output logic                  frame_error,
    output logic                  locked
);

    localparam int unsigned      CNT_W    = 6;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] SLOT_LEN = CNT_W'(SLOT_BITS);
    localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_SHIFT,
        ST_PAD
    } state_e;

    state_e                state_q, state_d;
    logic                  ws_s_q, ws_s_d;
    logic                  sd_s_q, sd_s_d;
    logic                  ws_prev_q, ws_prev_d;
    logic                  chan_q, chan_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] left_data_q, left_data_d;
    logic [DATA_WIDTH-1:0] right_data_q, right_data_d;
    logic                  left_valid_q, left_valid_d;
    logic                  right_valid_q, right_valid_d;
    logic                  frame_error_q, frame_error_d;
    logic                  locked_q, locked_d;
    logic                  ws_edge_c;

    // Slot tracking: chan_q is the channel of the slot currently being received (1 = right).
    always_comb begin
        ws_s_d        = ws_in;
        sd_s_d        = sd_in;
        ws_prev_d     = ws_s_q;
        state_d       = state_q;
        chan_d        = chan_q;
        cnt_d         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        shreg_d       = shreg_q;
        left_data_d   = left_data_q;
        right_data_d  = right_data_q;
        left_valid_d  = 1'b0;
        right_valid_d = 1'b0;
        frame_error_d = 1'b0;
        locked_d      = locked_q;
        ws_edge_c     = ws_s_q != ws_prev_q;

        case (state_q)
            ST_UNLOCKED: begin
                if (ws_edge_c && !ws_s_q) begin
                    state_d = ST_SHIFT;
                    chan_d  = 1'b0;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_SHIFT, ST_PAD: begin
                if (ws_edge_c) begin
                    if (cnt_q == SLOT_LEN) begin
                        if (chan_q) begin
                            right_data_d  = shreg_q;
                            right_valid_d = 1'b1;
                        end else begin
                            left_data_d  = shreg_q;
                            left_valid_d = 1'b1;
                        end
                        locked_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                    state_d = ST_SHIFT;
                    chan_d  = ws_s_q;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q >= SLOT_LEN) begin
                    // Slot ran past its length with no ws edge: drop lock and reacquire.
                    frame_error_d = 1'b1;
                    locked_d      = 1'b0;
                    state_d       = ST_UNLOCKED;
                end else if (state_q == ST_SHIFT) begin
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], sd_s_q};
                    if (cnt_q == DATA_LEN) begin
                        state_d = ST_PAD;
                    end
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

`ifdef I2S_RX_ERR_CNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Saturating error counter; clear wins over a coinciding error pulse.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clear) begin
            err_count_d = '0;
        end else if (frame_error_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`endif

    always_ff @(posedge serial_clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_UNLOCKED;
            ws_s_q        <= 1'b1;
            sd_s_q        <= 1'b0;
            ws_prev_q     <= 1'b1;
            chan_q        <= 1'b0;
            cnt_q         <= '0;
            shreg_q       <= '0;
            left_data_q   <= '0;
            right_data_q  <= '0;
            left_valid_q  <= 1'b0;
            right_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            locked_q      <= 1'b0;
`ifdef I2S_RX_ERR_CNT_EN
            err_count_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ws_s_q        <= ws_s_d;
            sd_s_q        <= sd_s_d;
            ws_prev_q     <= ws_prev_d;
            chan_q        <= chan_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            left_data_q   <= left_data_d;
            right_data_q  <= right_data_d;
            left_valid_q  <= left_valid_d;
            right_valid_q <= right_valid_d;
            frame_error_q <= frame_error_d;
            locked_q      <= locked_d;
`ifdef I2S_RX_ERR_CNT_EN
            err_count_q   <= err_count_d;
`endif
        end
    end

    assign left_data   = left_data_q;
    assign right_data  = right_data_q;
    assign left_valid  = left_valid_q;
    assign right_valid = right_valid_q;
    assign frame_error = frame_error_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_i2s_frame_receiver.sv
// Scoreboard bench for i2s_frame_receiver: directed I2S slots push expected events, a negedge monitor pops and compares.
// Define I2S_RX_ERR_CNT_EN to also exercise the error counter.
module tb_i2s_frame_receiver;

    localparam int unsigned DW    = 16;
    localparam int unsigned SB    = 17;
    localparam int unsigned FRAME = 2 * SB;
    // First slot bit driven -> closing edge driven SB later -> input register -> output register.
    localparam int unsigned LAT   = SB + 2;

    typedef enum logic [1:0] {EV_LEFT, EV_RIGHT, EV_ERR} ev_e;
    typedef struct packed {
        ev_e           kind;
        logic [DW-1:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned lv_cyc[$];
    int unsigned err_last = 0;
    int unsigned cyc      = 0;
    int unsigned t_fall   = 0;
    int unsigned t_long   = 0;
    int          checks   = 0;
    int          errors   = 0;

    logic          serial_clk = 1'b0;
    logic          reset      = 1'b0;
    logic          ws_in      = 1'b1;
    logic          sd_in      = 1'b0;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          left_valid;
    logic          right_valid;
    logic          frame_error;
    logic          locked;
`ifdef I2S_RX_ERR_CNT_EN
    logic          err_clear = 1'b0;
    logic [7:0]    err_count;
`endif

    i2s_frame_receiver #(.DATA_WIDTH(DW), .SLOT_BITS(SB)) dut (
        .serial_clk (serial_clk),
        .reset      (reset),
        .ws_in      (ws_in),
        .sd_in      (sd_in),
`ifdef I2S_RX_ERR_CNT_EN
        .err_clear  (err_clear),
        .err_count  (err_count),
`endif
        .left_data  (left_data),
        .right_data (right_data),
        .left_valid (left_valid),
        .right_valid(right_valid),
        .frame_error(frame_error),
        .locked     (locked)
    );

    always #5 serial_clk = ~serial_clk;
    always @(posedge serial_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input ev_e kind, input logic [DW-1:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input ev_e kind, input logic [DW-1:0] data);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d data 0x%0h, required no event", kind, data);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            check("event_data", 32'(data), 32'(e.data));
        end
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    always @(negedge serial_clk) begin
        if (reset) begin
            if (left_valid || right_valid)
                check("valid_exclusive", 32'(left_valid & right_valid), 32'd0);
            if (left_valid) begin
                lv_cyc.push_back(cyc);
                pop_cmp(EV_LEFT, left_data);
            end
            if (right_valid)
                pop_cmp(EV_RIGHT, right_data);
            if (frame_error) begin
                err_last = cyc;
                pop_cmp(EV_ERR, '0);
            end
        end
    end

    task automatic drive_bit(input logic w, input logic d);
        ws_in = w;
        sd_in = d;
        @(posedge serial_clk);
        #1;
    endtask

    // One slot: delay bit, DW data bits MSB-first, then zero padding (len may be short or long).
    task automatic send_slot(input logic w, input logic [DW-1:0] word, input int len);
        logic [DW-1:0] sh;
        logic          b;
        sh = word;
        for (int i = 0; i < len; i++) begin
            b = 1'b0;
            if (i >= 1 && i <= int'(DW)) begin
                b  = sh[DW-1];
                sh = sh << 1;
            end
            drive_bit(w, b);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_left_data"},   32'(left_data),   32'd0);
        check({tag, "_right_data"},  32'(right_data),  32'd0);
        check({tag, "_left_valid"},  32'(left_valid),  32'd0);
        check({tag, "_right_valid"}, 32'(right_valid), 32'd0);
        check({tag, "_frame_error"}, 32'(frame_error), 32'd0);
        check({tag, "_locked"},      32'(locked),      32'd0);
`ifdef I2S_RX_ERR_CNT_EN
        check({tag, "_err_count"},   32'(err_count),   32'd0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, released while ws_in = 1.
        repeat (2) @(posedge serial_clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;

        // Acquisition and nominal loopback: left ramps 50, 200, 350; right is 0.
        for (int i = 0; i < 6; i++) drive_bit(1'b1, 1'b0);
        t_fall = cyc;
        for (int i = 0; i < 3; i++) begin
            push(EV_LEFT, DW'(50 + 150 * i));
            send_slot(1'b0, DW'(50 + 150 * i), SB);
            push(EV_RIGHT, '0);
            send_slot(1'b1, '0, SB);
        end
        if (lv_cyc.size() < 3) begin
            checks++;
            errors++;
            $display("FAIL acq_left_pulses: got %0d, required 3", lv_cyc.size());
        end else begin
            check("acq_latency",  lv_cyc[0] - t_fall,    LAT);
            check("left_period1", lv_cyc[1] - lv_cyc[0], FRAME);
            check("left_period2", lv_cyc[2] - lv_cyc[1], FRAME);
        end
        check("locked_after_first", 32'(locked), 32'd1);

        // Short slot: ws toggles after 10 bits with 0xA5A5 in flight.
        push(EV_ERR, '0);
        send_slot(1'b0, 16'hA5A5, 10);
        push(EV_RIGHT, 16'h0F0F);
        send_slot(1'b1, 16'h0F0F, SB);
        check("short_left_held", 32'(left_data), 32'd350);
        push(EV_LEFT, 16'h1111);
        send_slot(1'b0, 16'h1111, SB);
        push(EV_RIGHT, '0);
        send_slot(1'b1, '0, SB);

        // Long slot: ws held low for 25 bits; error at sample 18, then relock.
        push(EV_ERR, '0);
        t_long = cyc;
        send_slot(1'b0, 16'h7777, 25);
        check("long_locked_low", 32'(locked), 32'd0);
        check("long_err_time", err_last - t_long, LAT);
        send_slot(1'b1, '0, SB);
        push(EV_LEFT, 16'h2222);
        send_slot(1'b0, 16'h2222, SB);
        push(EV_RIGHT, 16'h3333);
        send_slot(1'b1, 16'h3333, SB);
        push(EV_LEFT, 16'h4444);
        send_slot(1'b0, 16'h4444, SB);
        check("relocked", 32'(locked), 32'd1);
        send_slot(1'b1, '0, SB);

`ifdef I2S_RX_ERR_CNT_EN
        // Error counter: 300 short slots saturate it, then clear and clear-vs-increment.
        push(EV_RIGHT, '0);
        for (int i = 0; i < 301; i++) begin
            if (i > 0) push(EV_ERR, '0);
            send_slot(1'(i % 2), '0, 10);
        end
        check("err_cnt_saturated", 32'(err_count), 32'd255);
        push(EV_ERR, '0);
        for (int i = 0; i < 10; i++) begin
            err_clear = (i == 0) || (i == 2);
            if (i == 2) check("err_cnt_cleared", 32'(err_count), 32'd0);
            if (i == 4) check("err_cnt_clear_wins", 32'(err_count), 32'd0);
            drive_bit(1'b1, 1'b0);
        end
        err_clear = 1'b0;
`endif

        // Async reset mid-SHIFT after 7 data bits of 0x1234, then a full frame.
        reset = 1'b0;
        drive_bit(1'b1, 1'b0);
        reset = 1'b1;
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        send_slot(1'b0, 16'h1234, 8);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        ws_in = 1'b1;
        @(posedge serial_clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
        push(EV_LEFT, 16'h1234);
        send_slot(1'b0, 16'h1234, SB);
        push(EV_RIGHT, 16'h5678);
        send_slot(1'b1, 16'h5678, SB);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0);
        check("final_left_data",  32'(left_data),  32'h1234);
        check("final_right_data", 32'(right_data), 32'h5678);
        check("final_locked",     32'(locked),     32'd1);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
